// File: rtl/inst_ram_pkg.sv
// Shared constants and FSM state encoding for the instruction RAM loader.
// Optional feature macro: INST_LOADER_CSUM_EN adds the ST_CSUM state.
package inst_ram_pkg;

  localparam int INST_RAM_DEPTH  = 512;
  localparam int INST_RAM_ADDR_W = 9;
  localparam int INST_RAM_DATA_W = 32;
  localparam int INST_RAM_LEN_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3
`ifdef INST_LOADER_CSUM_EN
    , ST_CSUM = 3'd4
`endif
  } loader_state_e;

  // Image length is legal when it is nonzero and fits in the RAM.
  function automatic logic len_legal(input logic [INST_RAM_LEN_W-1:0] len, input int depth);
    return (len != '0) && (int'(len) <= depth);
  endfunction

endpackage

// File: rtl/inst_ram_loader_byte_packer.sv
// Little-endian byte-to-word packer.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clr_i               restart at lane 0
//   in_valid_i          a byte is accepted this cycle
//   in_data_i [7:0]     byte payload
//   word_o [31:0]       assembled word (valid together with word_valid_o)
//   word_valid_o        the accepted byte completes a word
// Only lanes 0..2 are stored; lane 3 is the byte arriving right now, so the
// completed word is available in the same cycle as the fourth handshake.
module inst_ram_loader_byte_packer
  import inst_ram_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       in_valid_i,
  input  logic [7:0]                 in_data_i,
  output logic [INST_RAM_DATA_W-1:0] word_o,
  output logic                       word_valid_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] buf_q, buf_d;

  always_comb begin
    lane_d = lane_q;
    buf_d  = buf_q;
    if (clr_i) begin
      lane_d = '0;
    end else if (in_valid_i) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    buf_d[7:0]   = in_data_i;
        2'd1:    buf_d[15:8]  = in_data_i;
        2'd2:    buf_d[23:16] = in_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      buf_q  <= '0;
    end else begin
      lane_q <= lane_d;
      buf_q  <= buf_d;
    end
  end

  assign word_o       = {in_data_i, buf_q};
  assign word_valid_o = in_valid_i && (lane_q == 2'd3);

endmodule

// File: rtl/inst_ram_loader.sv
// Instruction RAM loader: receives a byte stream, packs little-endian words
// and writes them through SRAM port 0 from address 0 upward, holding the
// core in reset until the image is complete.
// Optional feature macro: INST_LOADER_CSUM_EN (trailing 4-byte wrapping-sum
// checksum; mismatch leaves the core in reset and raises err).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, len_words[9:0]      load request and image length in words
//   byte_valid, byte_data[7:0] byte source; byte_ready is the handshake back
//   sram_csb0/web0/wmask0/addr0/din0   SRAM write port 0 (registered)
//   busy, done, err            status; err is sticky until the next good start
//   core_rst_n                 core reset, released only on a good load
//
// state    | meaning
// ST_IDLE  | waiting for first start
// ST_RECV  | collecting 4 bytes of the current word
// ST_WRITE | one-cycle SRAM write strobe
// ST_CSUM  | collecting the 4 checksum bytes (optional)
// ST_DONE  | image loaded (or checksum failed), waiting for restart
module inst_ram_loader
  import inst_ram_pkg::*;
#(
  parameter int ADDR_W = INST_RAM_ADDR_W,
  parameter int DEPTH  = INST_RAM_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [INST_RAM_LEN_W-1:0] len_words,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  output logic                      byte_ready,
  output logic                      sram_csb0,
  output logic                      sram_web0,
  output logic [3:0]                sram_wmask0,
  output logic [ADDR_W-1:0]         sram_addr0,
  output logic [31:0]               sram_din0,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      core_rst_n
);

  loader_state_e state_q, state_d;

  logic [INST_RAM_LEN_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0]         word_cnt_q, word_cnt_d;
  logic                      ready_q, ready_d;
  logic                      csb_q, csb_d;
  logic                      web_q, web_d;
  logic [3:0]                wmask_q, wmask_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [31:0]               din_q, din_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      core_rst_n_q, core_rst_n_d;
`ifdef INST_LOADER_CSUM_EN
  logic [31:0]               sum_q, sum_d;
`endif

  logic        xfer;
  logic        start_ok;
  logic        last_word;
  logic [31:0] word;
  logic        word_valid;

  assign xfer      = byte_valid && ready_q;
  assign last_word = (INST_RAM_LEN_W'(word_cnt_q) == (len_q - INST_RAM_LEN_W'(1)));

  inst_ram_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (start_ok),
    .in_valid_i   (xfer),
    .in_data_i    (byte_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    ready_d      = ready_q;
    csb_d        = 1'b1;
    web_d        = 1'b1;
    wmask_d      = 4'h0;
    addr_d       = addr_q;
    din_d        = din_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    core_rst_n_d = core_rst_n_q;
`ifdef INST_LOADER_CSUM_EN
    sum_d        = sum_q;
`endif
    start_ok     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (len_legal(len_words, DEPTH)) begin
            start_ok     = 1'b1;
            len_d        = len_words;
            word_cnt_d   = '0;
            err_d        = 1'b0;
            done_d       = 1'b0;
            core_rst_n_d = 1'b0;
            busy_d       = 1'b1;
            ready_d      = 1'b1;
`ifdef INST_LOADER_CSUM_EN
            sum_d        = '0;
`endif
            state_d      = ST_RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (word_valid) begin
          ready_d = 1'b0;
          csb_d   = 1'b0;
          web_d   = 1'b0;
          wmask_d = 4'hF;
          addr_d  = word_cnt_q;
          din_d   = word;
`ifdef INST_LOADER_CSUM_EN
          sum_d   = sum_q + word;
`endif
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        word_cnt_d = word_cnt_q + ADDR_W'(1);
        if (last_word) begin
`ifdef INST_LOADER_CSUM_EN
          ready_d      = 1'b1;
          state_d      = ST_CSUM;
`else
          busy_d       = 1'b0;
          done_d       = 1'b1;
          core_rst_n_d = 1'b1;
          state_d      = ST_DONE;
`endif
        end else begin
          ready_d = 1'b1;
          state_d = ST_RECV;
        end
      end
`ifdef INST_LOADER_CSUM_EN
      ST_CSUM: begin
        if (word_valid) begin
          ready_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_DONE;
          if (word == sum_q) begin
            done_d       = 1'b1;
            core_rst_n_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      ready_q      <= 1'b0;
      csb_q        <= 1'b1;
      web_q        <= 1'b1;
      wmask_q      <= 4'h0;
      addr_q       <= '0;
      din_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
`ifdef INST_LOADER_CSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      ready_q      <= ready_d;
      csb_q        <= csb_d;
      web_q        <= web_d;
      wmask_q      <= wmask_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_rst_n_q <= core_rst_n_d;
`ifdef INST_LOADER_CSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign byte_ready  = ready_q;
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign core_rst_n  = core_rst_n_q;

endmodule

// File: tb/tb_inst_ram_loader.sv
// Self-checking bench for inst_ram_loader. The reference model is an image
// array: every word w is expected as one write of img[w] at address w, fed
// as four little-endian bytes. Build with INST_LOADER_CSUM_EN to exercise
// the checksum trailer.
module tb_inst_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  len_words = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        sram_csb0;
  logic        sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic        busy;
  logic        done;
  logic        err;
  logic        core_rst_n;

  inst_ram_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .len_words   (len_words),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .core_rst_n  (core_rst_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] img [512];
  logic [8:0]  exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every cycle with the chip select low must be the next expected write.
  always @(negedge clk) begin
    if (rst_n && !sram_csb0) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_write", {23'b0, sram_addr0}, 32'hFFFF_FFFF);
      end else begin
        check("wr_addr", {23'b0, sram_addr0}, {23'b0, exp_addr_q.pop_front()});
        check("wr_data", sram_din0, exp_data_q.pop_front());
        check("wr_web", {31'b0, sram_web0}, 32'd0);
        check("wr_mask", {28'b0, sram_wmask0}, 32'hF);
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, {31'b0, byte_ready}, 0);
    check({tag, "_csb"}, {31'b0, sram_csb0}, 1);
    check({tag, "_web"}, {31'b0, sram_web0}, 1);
    check({tag, "_wmask"}, {28'b0, sram_wmask0}, 0);
    check({tag, "_addr"}, {23'b0, sram_addr0}, 0);
    check({tag, "_din"}, sram_din0, 0);
    check({tag, "_busy"}, {31'b0, busy}, 0);
    check({tag, "_done"}, {31'b0, done}, 0);
    check({tag, "_err"}, {31'b0, err}, 0);
    check({tag, "_core_rst"}, {31'b0, core_rst_n}, 0);
  endtask

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic do_start(input int len);
    logic [9:0] l;
    l = len[9:0];
    start     = 1'b1;
    len_words = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int n;
    repeat (stall) @(posedge clk);
    if (stall > 0) #1;
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    @(negedge clk);
    while (!byte_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_stall);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, max_stall));
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && !err && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("end_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic expect_image(input int len);
    for (int w = 0; w < len; w++) begin
      exp_addr_q.push_back(9'(w));
      exp_data_q.push_back(img[w]);
    end
  endtask

  task automatic run_load(input int len, input int max_stall, input logic bad_csum);
    logic exp_ok;
    logic [31:0] sum;
    sum = '0;
    exp_ok = !bad_csum;
    expect_image(len);
    for (int w = 0; w < len; w++) sum += img[w];
    do_start(len);
    check("load_busy", {31'b0, busy}, 1);
    check("load_core_rst", {31'b0, core_rst_n}, 0);
    check("load_err_clr", {31'b0, err}, 0);
    for (int w = 0; w < len; w++) send_word(img[w], max_stall);
`ifdef INST_LOADER_CSUM_EN
    send_word(sum + {31'b0, bad_csum}, max_stall);
`endif
    wait_end();
    check("queue_drained", exp_addr_q.size(), 0);
    check("end_busy", {31'b0, busy}, 0);
    check("end_done", {31'b0, done}, {31'b0, exp_ok});
    check("end_err", {31'b0, err}, {31'b0, !exp_ok});
    check("end_core_rst", {31'b0, core_rst_n}, {31'b0, exp_ok});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    #12;
    check_reset("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Illegal lengths from IDLE.
    do_start(0);
    check("len0_err", {31'b0, err}, 1);
    check("len0_busy", {31'b0, busy}, 0);
    check("len0_csb", {31'b0, sram_csb0}, 1);
    check("len0_core_rst", {31'b0, core_rst_n}, 0);
    @(posedge clk); #1;
    do_start(513);
    check("len513_err", {31'b0, err}, 1);
    check("len513_busy", {31'b0, busy}, 0);
    check("len513_ready", {31'b0, byte_ready}, 0);
    check("len513_core_rst", {31'b0, core_rst_n}, 0);
    repeat (3) @(posedge clk);
    #1;

    // Directed two-word image.
    img[0] = 32'h1234_5678;
    img[1] = 32'hDEAD_BEEF;
    run_load(2, 0, 1'b0);

    // Seven-cycle source stall after the second byte of a word.
    img[0] = 32'h1234_5678;
    expect_image(1);
    do_start(1);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      check("stall_no_write", {31'b0, sram_csb0}, 1);
    end
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    wait_end();
    check("stall_drained", exp_addr_q.size(), 0);
    check("stall_done", {31'b0, done}, 1);

    // Random images with random source stalls.
    for (int r = 0; r < 4; r++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int w = 0; w < len; w++) img[w] = $urandom;
      run_load(len, 3, 1'b0);
    end

    // Full-depth image, data equals address.
    for (int w = 0; w < 512; w++) img[w] = w;
    run_load(512, 0, 1'b0);
    check("full_last_addr", {23'b0, sram_addr0}, 32'h1FF);
    check("full_last_din", sram_din0, 32'h1FF);

    // Reset in the middle of word 3 of a 10-word load.
    for (int w = 0; w < 10; w++) img[w] = $urandom;
    expect_image(10);
    do_start(10);
    send_word(img[0], 1);
    send_word(img[1], 1);
    send_byte(img[2][7:0], 0);
    send_byte(img[2][15:8], 0);
    check("mid_written", 32'(10 - exp_addr_q.size()), 2);
    rst_n = 1'b0;
    #2;
    check_reset("mid_rst");
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int w = 0; w < 3; w++) img[w] = $urandom;
    run_load(3, 2, 1'b0);

`ifdef INST_LOADER_CSUM_EN
    img[0] = 32'd1;
    img[1] = 32'd2;
    run_load(2, 0, 1'b0);
    run_load(2, 0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_ram_loader.md
Name: inst_ram_loader

Overview:
- Write-side companion to the instruction RAM read port. Drives write port 0 (csb0/web0/wmask0/addr0/din0) of the sky130 1rw1r 32x512 SRAM.
- Accepts a byte stream over a valid/ready handshake (fed by the boot UART). Packs bytes little-endian into 32-bit words and writes them from address 0 upward.
- Holds the core in reset until the image is fully loaded.

Parameters:
- ADDR_W, 9, SRAM word-address width.
- DEPTH, 512, SRAM depth in words; maximum legal image length.

Ports:
- clk  in  1  system clock; also drives SRAM clk0 externally.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle load request; sampled only in IDLE or DONE.
- len_words  in  10  image length in words, 1..DEPTH; sampled with start.
- byte_valid  in  1  source has a byte.
- byte_data  in  8  byte payload.
- byte_ready  out  1  loader accepts a byte; transfer occurs when valid&&ready.
- sram_csb0  out  1  SRAM port-0 chip select, active-low.
- sram_web0  out  1  SRAM port-0 write enable, active-low.
- sram_wmask0  out  4  byte write mask.
- sram_addr0  out  ADDR_W  word address.
- sram_din0  out  32  write data.
- busy  out  1  load in progress.
- done  out  1  image loaded successfully.
- err  out  1  sticky error flag, cleared by the next accepted start.
- core_rst_n  out  1  core reset, active-low; released only on successful done.

Behaviour:
- Reset values: byte_ready=0, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, busy=0, done=0, err=0, core_rst_n=0.
- All outputs are registered. SRAM inputs change after a clk edge and are sampled by the SRAM on the following edge.
- FSM states: IDLE, RECV, WRITE, DONE (plus CSUM when the optional feature is enabled).
- IDLE/DONE, start=1:
  - If len_words is 0 or greater than DEPTH: err=1, state unchanged.
  - Otherwise: latch len_words, clear word and byte counters, err=0, done=0, core_rst_n=0, busy=1, go to RECV.
- RECV:
  - byte_ready=1.
  - Each handshake writes byte_data into lane byte_cnt of the word buffer (lane 0 = bits 7:0), then increments byte_cnt.
  - On the handshake with byte_cnt==3: byte_ready=0 on the next cycle, go to WRITE.
- WRITE (exactly one cycle):
  - csb0=0, web0=0, wmask0=4'hF, addr0=word_cnt, din0=buffer.
  - Next cycle: csb0/web0 return to 1, word_cnt increments.
  - If word_cnt==len-1, go to DONE (or CSUM); otherwise go to RECV.
- Throughput: minimum 5 cycles per word. byte_valid stalls are allowed at any point without losing a partial word.
- DONE: busy=0, done=1, core_rst_n=1. Held until the next accepted start.
- start during RECV/WRITE is ignored.
- Address never wraps; the length check guarantees the last address is DEPTH-1.
- rst_n asserted mid-load: immediate return to reset values. The partially written RAM contents are undefined and not cleared.
- Port 1 (core fetch) never conflicts with loader writes, because the core is held in reset whenever busy=1.

Optional Feature:
- Macro INST_LOADER_CSUM_EN.
- Defined:
  - After the last word, state CSUM accepts 4 more bytes (little-endian).
  - These are compared with the running 32-bit wrapping sum of all written words.
  - Match: DONE with done=1, core_rst_n=1.
  - Mismatch: DONE with err=1, done=0, core_rst_n=0.
- Undefined:
  - No CSUM state and no sum register.
  - err is set only by an illegal length.

Decomposition:
- Shared package/header inst_ram_pkg:
  - Constants INST_RAM_DEPTH=512, INST_RAM_ADDR_W=9, INST_RAM_DATA_W=32.
  - FSM state encodings.
- One natural sub-module: byte_packer. It holds the 4-byte little-endian buffer and 2-bit lane counter, and outputs word and word_valid.

Test Plan:
- Reset, then start with len_words=2, bytes 78 56 34 12 EF BE AD DE -> two single-cycle writes: addr0=0 din0=32'h12345678, then addr0=1 din0=32'hDEADBEEF. Then done=1, core_rst_n=1, busy=0.
- start with len_words=0, and separately with 513 -> err=1, no SRAM access (csb0 stays 1), busy=0, core_rst_n=0.
- byte_valid deasserted for 7 cycles after byte 2 of a word -> no write until byte 4 arrives; din0 still 32'h12345678.
- Full load, len_words=512, data = address -> last write at addr0=9'h1FF with din0=32'h1FF, then done; address never wraps.
- rst_n pulsed low during word 3 of a 10-word load -> all outputs return to reset values immediately. A fresh start then reloads from addr0=0.
- INST_LOADER_CSUM_EN defined, 2 words 1 and 2, checksum bytes 03 00 00 00 -> done=1. Checksum 04 00 00 00 -> err=1, done=0, core_rst_n=0.
